// File: rtl/cpu_seq_pkg.sv
// Shared types and opcode constants for the RV32I multi-cycle sequencer.
// Used by cpu_seq_ctrl, its timeout counter and the handshake interface.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6,
        S_HALT   = 3'd7
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Branches and SYSTEM never write rd, whatever the decoder flag says.
    function automatic logic rf_wr_ok(input logic [6:0] op);
        return (op[6:2] != OP_BRANCH[6:2]) && (op[6:2] != OP_SYSTEM[6:2]);
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Sequencer-side bundle: run/ack inputs, decoder flags, strobes and status.
// master = sequencer, slave = the memory/decoder/datapath side.
interface cpu_seq_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             imem_ack;
    logic             dmem_ack;
    logic [6:0]       op;
    logic             dec_regwr;
    logic             dec_memwr;
    logic             dec_memtoreg;
    logic             imem_req;
    logic             ir_we;
    logic             dmem_req;
    logic             dmem_we;
    logic             rf_we;
    logic             pc_we;
    logic             fault;
    logic             halted;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] instret;

    modport master (
        input  run, imem_ack, dmem_ack, op,
        input  dec_regwr, dec_memwr, dec_memtoreg,
        output imem_req, ir_we, dmem_req, dmem_we,
        output rf_we, pc_we, fault, halted,
        output state_o, instret
    );

    modport slave (
        output run, imem_ack, dmem_ack, op,
        output dec_regwr, dec_memwr, dec_memtoreg,
        input  imem_req, ir_we, dmem_req, dmem_we,
        input  rf_we, pc_we, fault, halted,
        input  state_o, instret
    );
endinterface

// File: rtl/seq_timeout_cnt.sv
// Bus-wait cycle counter shared by the FETCH and MEM waits.
module seq_timeout_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] lim_i,
    output logic         expired_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == lim_i);
endmodule

// File: rtl/cpu_seq_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer with bus timeout and retire counter.
// Define CPU_SEQ_HALT_EN to make the SYSTEM opcode stop the core in HALT.
module cpu_seq_ctrl
    import cpu_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 32
) (
    input  logic           clk,
    input  logic           rst,
    cpu_seq_ctrl_if.master bus
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic TMO_ON = (TIMEOUT_CYC != 0);
    localparam logic [CW-1:0] LIM =
        TMO_ON ? CW'(TIMEOUT_CYC - 1) : '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             wait_st, ack, tmo_exp, tmo;

    assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM);
    assign ack     = (state_q == S_FETCH) ? bus.imem_ack : bus.dmem_ack;

    seq_timeout_cnt #(.W(CW)) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!wait_st),
        .en_i      (wait_st && !ack && TMO_ON),
        .lim_i     (LIM),
        .expired_o (tmo_exp)
    );

    // Ack is examined first, so an ack on the limit cycle wins.
    assign tmo = TMO_ON && tmo_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        instret_d = instret_q;
        unique case (state_q)
            S_IDLE:   if (bus.run) state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ack) state_d = S_DECODE;
                else if (tmo)     state_d = S_FAULT;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = (bus.dec_memtoreg || bus.dec_memwr) ? S_MEM : S_WB;
`ifdef CPU_SEQ_HALT_EN
                if (bus.op == OP_SYSTEM) state_d = S_HALT;
`endif
            end
            S_MEM: begin
                if (bus.dmem_ack) state_d = S_WB;
                else if (tmo)     state_d = S_FAULT;
            end
            S_WB: begin
                instret_d = instret_q + 1'b1;
                state_d   = bus.run ? S_FETCH : S_IDLE;
            end
            S_FAULT:  state_d = S_FAULT;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req = 1'b0;
        bus.ir_we    = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.rf_we    = 1'b0;
        bus.pc_we    = 1'b0;
        bus.fault    = 1'b0;
        bus.halted   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_we    = bus.imem_ack;
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = bus.dec_memwr;
            end
            S_WB: begin
                bus.pc_we = 1'b1;
                bus.rf_we = bus.dec_regwr && rf_wr_ok(bus.op);
            end
            S_FAULT: bus.fault  = 1'b1;
            S_HALT:  bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.state_o = state_q;
    assign bus.instret = instret_q;
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: per-instruction records checked at pc_we.
module tb_cpu_seq_ctrl;
    import cpu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    cpu_seq_ctrl_if #(.CNT_W(32)) b ();
    cpu_seq_ctrl_if #(.CNT_W(32)) b2 ();

    cpu_seq_ctrl #(.TIMEOUT_CYC(255), .CNT_W(32)) dut (
        .clk (clk), .rst (rst), .bus (b)
    );
    cpu_seq_ctrl #(.TIMEOUT_CYC(4), .CNT_W(32)) dut2 (
        .clk (clk), .rst (rst2), .bus (b2)
    );

    typedef struct {
        int     lat;
        int     mreq;
        int     mwe;
        int     rfc;
        longint ir;
    } exp_t;

    exp_t   q[$];
    int     n_pass = 0;
    int     n_tot  = 0;
    longint exp_ir = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Monitor: collects one record per instruction, compares at pc_we.
    logic [2:0] prev = 3'd0;
    bit         trk = 0;
    int         cyc, mreq, mwe, rfc, irc;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            trk  = 0;
            prev = 3'd0;
        end else begin
            if (b.state_o == S_FETCH && prev != S_FETCH) begin
                trk = 1; cyc = 0; mreq = 0; mwe = 0; rfc = 0; irc = 0;
            end
            if (trk) begin
                cyc++;
                if (b.dmem_req) mreq++;
                if (b.dmem_we)  mwe = 1;
                if (b.rf_we)    rfc++;
                if (b.ir_we)    irc++;
            end
            if (b.pc_we) begin
                chk("sb_nonempty", longint'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("latency", cyc, e.lat);
                    chk("dmem_req_cycles", mreq, e.mreq);
                    chk("dmem_we_seen", mwe, e.mwe);
                    chk("rf_we_count", rfc, e.rfc);
                    chk("ir_we_count", irc, 1);
                    chk("instret_in_wb", b.instret, e.ir);
                end
                trk = 0;
            end
            prev = b.state_o;
        end
    end

    task automatic do_instr(
        input logic [6:0] op, input logic rw, input logic mw, input logic mt,
        input int dw, input bit keep,
        input int xlat, input int xmreq, input int xmwe, input int xrfc
    );
        exp_t e;
        b.op = op; b.dec_regwr = rw; b.dec_memwr = mw; b.dec_memtoreg = mt;
        b.imem_ack = 1'b1;
        b.dmem_ack = (dw <= 1);
        e.lat = xlat; e.mreq = xmreq; e.mwe = xmwe; e.rfc = xrfc; e.ir = exp_ir;
        exp_ir++;
        q.push_back(e);
        b.run = 1'b1;
        if (b.state_o == S_IDLE) @(negedge clk);
        if (!keep) b.run = 1'b0;
        if (dw > 1) begin
            for (int i = 0; i < 20 && b.state_o != S_MEM; i++) @(negedge clk);
            chk("reach_mem", b.state_o, S_MEM);
            for (int k = 1; k < dw; k++) @(negedge clk);
            b.dmem_ack = 1'b1;
        end
        for (int i = 0; i < 40 && !b.pc_we; i++) @(negedge clk);
        chk("reach_wb", b.pc_we, 1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        b.run = 0; b.imem_ack = 1; b.dmem_ack = 1; b.op = '0;
        b.dec_regwr = 0; b.dec_memwr = 0; b.dec_memtoreg = 0;
        b2.run = 0; b2.imem_ack = 0; b2.dmem_ack = 0; b2.op = 7'b0110011;
        b2.dec_regwr = 1; b2.dec_memwr = 0; b2.dec_memtoreg = 0;
        repeat (3) @(negedge clk);
        chk("reset_state", b.state_o, S_IDLE);
        chk("reset_outs", {b.imem_req, b.ir_we, b.dmem_req, b.dmem_we,
                           b.rf_we, b.pc_we, b.fault, b.halted}, 0);
        chk("reset_instret", b.instret, 0);
        rst = 0; rst2 = 0;
        @(negedge clk);
        chk("idle_no_run", b.state_o, S_IDLE);

        do_instr(7'b0110011, 1, 0, 0, 0, 0, 4, 0, 0, 1);
        chk("instret_after_alu", b.instret, 1);
        do_instr(OP_LOAD,    1, 0, 1, 3, 0, 7, 3, 0, 1);
        do_instr(OP_BRANCH,  1, 0, 0, 0, 0, 4, 0, 0, 0);
        do_instr(OP_STORE,   0, 1, 0, 1, 0, 5, 1, 1, 0);
        do_instr(7'b1101111, 1, 0, 0, 0, 1, 4, 0, 0, 1);
        do_instr(7'b0110011, 1, 0, 0, 0, 0, 4, 0, 0, 1);
        chk("idle_after_run_drop", b.state_o, S_IDLE);
        chk("instret_after_six", b.instret, exp_ir);

        // Reset in the middle of a load: abort, strobes drop at once.
        b.op = OP_LOAD; b.dec_regwr = 1; b.dec_memtoreg = 1; b.dec_memwr = 0;
        b.dmem_ack = 0; b.run = 1;
        for (int i = 0; i < 20 && b.state_o != S_MEM; i++) @(negedge clk);
        chk("rst_reach_mem", b.state_o, S_MEM);
        chk("rst_mem_req_before", b.dmem_req, 1);
        rst = 1;
        #1;
        chk("rst_mem_req_after", b.dmem_req, 0);
        chk("rst_mem_state", b.state_o, S_IDLE);
        chk("rst_mem_instret", b.instret, 0);
        exp_ir = 0;
        b.run = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        do_instr(7'b0110011, 1, 0, 0, 0, 0, 4, 0, 0, 1);

`ifdef CPU_SEQ_HALT_EN
        b.op = OP_SYSTEM; b.dec_regwr = 1; b.dec_memwr = 0; b.dec_memtoreg = 0;
        b.run = 1;
        @(negedge clk);
        b.run = 0;
        for (int i = 0; i < 20 && b.state_o != S_HALT; i++) @(negedge clk);
        chk("halt_state", b.state_o, S_HALT);
        chk("halt_flag", b.halted, 1);
        repeat (3) @(negedge clk);
        chk("halt_sticky", b.halted, 1);
        chk("halt_instret", b.instret, exp_ir);
`else
        do_instr(OP_SYSTEM, 1, 0, 0, 0, 0, 4, 0, 0, 0);
        chk("system_instret", b.instret, exp_ir);
`endif

        // Timeout instance: FETCH never acked.
        b2.run = 1;
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 20 && b2.state_o == S_FETCH; i++) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_fetch_cycles", n, 4);
        chk("tmo_fault_state", b2.state_o, S_FAULT);
        chk("tmo_fault_flag", b2.fault, 1);
        b2.run = 0; b2.imem_ack = 1; b2.dmem_ack = 1;
        repeat (3) @(negedge clk);
        chk("tmo_fault_sticky", b2.fault, 1);
        chk("tmo_fault_strobes",
            {b2.pc_we, b2.rf_we, b2.imem_req, b2.dmem_req}, 0);
        rst2 = 1;
        @(negedge clk);
        rst2 = 0;
        chk("tmo_rst_clears", b2.fault, 0);

        // Ack on the limit cycle wins over the timeout.
        b2.imem_ack = 0; b2.dmem_ack = 0; b2.dec_memtoreg = 1;
        b2.op = OP_LOAD; b2.run = 1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("tmo_4th_fetch", b2.state_o, S_FETCH);
        b2.imem_ack = 1;
        @(negedge clk);
        b2.run = 0;
        chk("tmo_ack_wins", b2.state_o, S_DECODE);
        chk("tmo_ack_no_fault", b2.fault, 0);

        // MEM wait times out on the same limit.
        for (int i = 0; i < 10 && b2.state_o != S_MEM; i++) @(negedge clk);
        n = 0;
        for (int i = 0; i < 20 && b2.state_o == S_MEM; i++) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_mem_cycles", n, 4);
        chk("tmo_mem_fault", b2.state_o, S_FAULT);

        repeat (2) @(negedge clk);
        chk("sb_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
